data_mem_controller: RTL and testbench

- Multi-cycle data-memory responder for the MEM stage.
- Accepts read and write requests driven by the MEM stage and holds the pipeline with `ready` until the access completes.
- Returns the read word, which the MEM stage register captures as its memory read value.
- Internal word-addressed memory array, with a fixed, parameterized wait-state latency.

---
 rtl/data_mem_controller_if.sv | 19 +
 rtl/data_mem_controller.sv | 99 +++++++++
 tb/tb_data_mem_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_controller_if.sv
// rtl/data_mem_controller_if.sv - MEM-stage to data-memory request/response bundle
interface data_mem_controller_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output MEM_R_EN, MEM_W_EN, address, wdata,
        input  rdata, ready
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/data_mem_controller.sv
// rtl/data_mem_controller.sv - multi-cycle data memory with fixed wait states; DATA_MEM_STALL_CNT_EN adds stall_cycles
module data_mem_controller #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_controller_if.slave bus
`ifdef DATA_MEM_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          wr_q;
    logic [31:0]   mem [DEPTH];
    logic          req;
    logic          access_edge;

    assign req         = bus.MEM_R_EN | bus.MEM_W_EN;
    assign access_edge = (state == BUSY) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUSY;
            BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = 1'b0;
        case (state)
            IDLE:    bus.ready = ~req;
            DONE:    bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    // Request fields are captured in IDLE so a flush during BUSY cannot alter the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            bus.rdata <= 32'h0;
        end else begin
            if (state == IDLE && req) begin
                idx_q   <= AW'((bus.address - ADDR_BASE) >> 2);
                wdata_q <= bus.wdata;
                wr_q    <= bus.MEM_W_EN;
                cnt     <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + CW'(1);
            end
            if (access_edge && !wr_q) begin
                bus.rdata <= mem[idx_q];
            end
        end
    end

    // No reset on the array; a reset mid-BUSY forces IDLE so access_edge never fires.
    always_ff @(posedge clk) begin
        if (access_edge && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef DATA_MEM_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'h0;
        end else if (!bus.ready && req) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_data_mem_controller.sv
// tb/tb_data_mem_controller.sv - table-driven checks of data_mem_controller timing and data
module tb_data_mem_controller;
    localparam int WAIT_CYCLES = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    data_mem_controller_if bus ();
`ifdef DATA_MEM_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    data_mem_controller #(
        .ADDR_BASE   (32'd1024),
        .DEPTH       (64),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef DATA_MEM_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r_en;
        logic        w_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          drop_cyc;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge (cycle 0); leaves just after the edge ending DONE.
    task automatic do_access(input vec_t v);
        int first;
        first = -1;
        bus.MEM_R_EN = v.r_en;
        bus.MEM_W_EN = v.w_en;
        bus.address  = v.addr;
        bus.wdata    = v.wdata;
        for (int k = 0; k <= 20 && first < 0; k++) begin
            if (k == v.drop_cyc) begin
                bus.MEM_R_EN = 1'b0;
                bus.MEM_W_EN = 1'b0;
            end
            @(negedge clk);
            if (bus.ready) first = k;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check({v.name, " ready cycle"}, 32'(first), 32'(WAIT_CYCLES + 1));
        if (v.chk_rdata) check({v.name, " rdata"}, bus.rdata, v.exp_rdata);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        vecs.push_back('{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, -1, 1'b0, 32'h0,        "wr 1028"});
        vecs.push_back('{1'b1, 1'b0, 32'd1028, 32'h0,        -1, 1'b1, 32'hDEADBEEF, "rd 1028"});
        vecs.push_back('{1'b0, 1'b1, 32'd1280, 32'h12345678, -1, 1'b0, 32'h0,        "wr wrap 1280"});
        vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'h0,        -1, 1'b1, 32'h12345678, "rd 1024"});
        vecs.push_back('{1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, -1, 1'b1, 32'h12345678, "rw both 1032"});
        vecs.push_back('{1'b1, 1'b0, 32'd1032, 32'h0,        -1, 1'b1, 32'hA5A5A5A5, "rd 1032"});
        vecs.push_back('{1'b0, 1'b1, 32'd1036, 32'h0,        -1, 1'b0, 32'h0,        "wr0 1036"});
        vecs.push_back('{1'b0, 1'b1, 32'd1036, 32'hFFFFFFFF,  2, 1'b0, 32'h0,        "wr flush 1036"});
        vecs.push_back('{1'b1, 1'b0, 32'd1036, 32'h0,        -1, 1'b1, 32'hFFFFFFFF, "rd 1036"});
        vecs.push_back('{1'b1, 1'b0, 32'd1027, 32'h0,        -1, 1'b1, 32'h12345678, "rd low bits 1027"});
        vecs.push_back('{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, -1, 1'b0, 32'h0,        "wr below base 1020"});
        vecs.push_back('{1'b1, 1'b0, 32'd1276, 32'h0,        -1, 1'b1, 32'hCAFEF00D, "rd idx63 1276"});

        idle_bus();
        bus.address = 32'd0;
        bus.wdata   = 32'd0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("reset rdata", bus.rdata, 32'h0);
        check("reset ready idle", 32'(bus.ready), 32'd1);
        bus.MEM_R_EN = 1'b1;
        bus.address  = 32'd1024;
        #1;
        check("comb ready drop", 32'(bus.ready), 32'd0);
        idle_bus();
        #1;
        check("comb ready restore", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;

        foreach (vecs[i]) do_access(vecs[i]);
        idle_bus();
        @(posedge clk);
        #1;

        // Reset in the middle of a write: access aborted, memory keeps old word.
        v = '{1'b0, 1'b1, 32'd1040, 32'h0, -1, 1'b0, 32'h0, "wr0 1040"};
        do_access(v);
        bus.MEM_W_EN = 1'b1;
        bus.wdata    = 32'h11111111;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        check("mid-busy rst ready with req", 32'(bus.ready), 32'd0);
        idle_bus();
        #1;
        check("mid-busy rst ready idle", 32'(bus.ready), 32'd1);
        check("mid-busy rst rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        v = '{1'b1, 1'b0, 32'd1040, 32'h0, -1, 1'b1, 32'h0, "rd after abort 1040"};
        do_access(v);
        idle_bus();
        @(posedge clk);
        #1;

`ifdef DATA_MEM_STALL_CNT_EN
        begin
            logic [31:0] before;
            before = stall_cycles;
            v = '{1'b1, 1'b0, 32'd1028, 32'h0, -1, 1'b1, 32'hDEADBEEF, "stall rd a"};
            do_access(v);
            v = '{1'b1, 1'b0, 32'd1032, 32'h0, -1, 1'b1, 32'hA5A5A5A5, "stall rd b"};
            do_access(v);
            idle_bus();
            @(negedge clk);
            check("stall_cycles delta", stall_cycles - before, 32'd12);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
